// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-FF synchroniser, debounce, press-edge pulse
// and optional hold-to-repeat. All outputs are registered.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | released, or pressed on a non-repeat channel
// S_WAIT   | pressed, counting REPEAT_DELAY toward the first repeat pulse
// S_REPEAT | pressed, emitting a pulse every REPEAT_PERIOD cycles
module button_conditioner #(
    parameter int                   N_BUTTONS       = 5,
    parameter int                   DEBOUNCE_CYCLES = 1_000_000,
    parameter int                   REPEAT_DELAY    = 50_000_000,
    parameter int                   REPEAT_PERIOD   = 10_000_000,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(5'b11110)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] button_in,
    output logic [N_BUTTONS-1:0] button_pulse,
    output logic [N_BUTTONS-1:0] button_level,
    output logic [N_BUTTONS-1:0] button_held,
    output logic                 any_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    localparam logic [DW-1:0] DB_TC     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_TC  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TC = RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [N_BUTTONS-1:0] pulse_nx_all;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic [DW-1:0] cnt;
        logic [DW-1:0] cnt_nx;
        logic          level_q;
        logic          level_nx;
        logic          pulse_q;
        logic          pulse_nx;
        logic          held_q;
        logic          held_nx;
        logic [1:0]    state;
        logic [1:0]    state_nx;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nx;
        logic          accept;
        logic          rise;
        logic          fall;

        always_comb begin
            cnt_nx   = '0;
            level_nx = level_q;
            accept   = 1'b0;
            if (sync2 != level_q) begin
                if (cnt == DB_TC) begin
                    accept   = 1'b1;
                    level_nx = sync2;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            rise = accept & sync2;
            fall = accept & ~sync2;

            state_nx = state;
            rcnt_nx  = rcnt;
            pulse_nx = 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        pulse_nx = 1'b1;
                        rcnt_nx  = '0;
                        if (REPEAT_MASK[i]) state_nx = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A release landing on a repeat edge takes priority.
                    if (fall) begin
                        state_nx = S_IDLE;
                        rcnt_nx  = '0;
                    end else if (rcnt == DELAY_TC) begin
                        pulse_nx = 1'b1;
                        rcnt_nx  = '0;
                        state_nx = S_REPEAT;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (fall) begin
                        state_nx = S_IDLE;
                        rcnt_nx  = '0;
                    end else if (rcnt == PERIOD_TC) begin
                        pulse_nx = 1'b1;
                        rcnt_nx  = '0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    rcnt_nx  = '0;
                end
            endcase
            held_nx = (state_nx == S_REPEAT);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                cnt     <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
                state   <= S_IDLE;
                rcnt    <= '0;
            end else begin
                sync1   <= button_in[i];
                sync2   <= sync1;
                cnt     <= cnt_nx;
                level_q <= level_nx;
                pulse_q <= pulse_nx;
                held_q  <= held_nx;
                state   <= state_nx;
                rcnt    <= rcnt_nx;
            end
        end

        assign pulse_nx_all[i] = pulse_nx;
        assign button_pulse[i] = pulse_q;
        assign button_level[i] = level_q;
        assign button_held[i]  = held_q;
    end

    // Registered from the same next-state terms so it lines up with button_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_pulse <= 1'b0;
        end else begin
            any_pulse <= |pulse_nx_all;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Inputs change on negedge; outputs are sampled on the next negedge.
module tb_button_conditioner;
    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] button_in;
    logic [N-1:0] button_pulse;
    logic [N-1:0] button_level;
    logic [N-1:0] button_held;
    logic         any_pulse;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (5'b11110)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_in   (button_in),
        .button_pulse(button_pulse),
        .button_level(button_level),
        .button_held (button_held),
        .any_pulse   (any_pulse)
    );

    typedef struct {
        logic [4:0] bin;
        logic [4:0] pulse;
        logic [4:0] level;
        logic [4:0] held;
        logic       any;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int b, input int budget);
        int n;
        n = 0;
        while (button_pulse[b] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wait_pulse_bit%0d", b), 32'(button_pulse[b]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        logic anyheld;
        logic [2:0] exp3;

        // Clean press on bit 1: rise applied at row 0, released at row 10.
        vecs[0]  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[1]  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[2]  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[3]  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[4]  = '{5'b00010, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[5]  = '{5'b00010, 5'b00010, 5'b00010, 5'b00000, 1'b1};
        vecs[6]  = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[7]  = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[8]  = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[9]  = '{5'b00010, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[10] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[11] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[12] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[13] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[14] = '{5'b00000, 5'b00000, 5'b00010, 5'b00000, 1'b0};
        vecs[15] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[16] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[17] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[18] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[19] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0};

        rst       = 1'b1;
        button_in = '0;
        tick();
        tick();
        check("reset_state", {button_pulse, button_level, button_held, any_pulse}, 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 20; k++) begin
            button_in = vecs[k].bin;
            tick();
            check($sformatf("vec%0d", k),
                  {button_pulse, button_level, button_held, any_pulse},
                  {vecs[k].pulse, vecs[k].level, vecs[k].held, vecs[k].any});
        end

        // Bouncing bit 2: 2-cycle toggles for 12 cycles, then steady high from step 12.
        for (int s = 0; s < 19; s++) begin
            button_in = (s < 12) ? {2'b00, ((s / 2) % 2 == 0), 2'b00} : 5'b00100;
            tick();
            check($sformatf("bounce_s%0d", s), {button_pulse, button_level[2]},
                  (s == 17) ? {5'b00100, 1'b1} : {5'b00000, (s >= 17)});
        end
        button_in = '0;
        repeat (10) tick();
        check("bounce_release_level", 32'(button_level), 32'd0);

        // Hold bit 3: input drops before edge 47 so the level falls on repeat edge 52.
        button_in = 5'b01000;
        wait_pulse(3, 12);
        check("hold3_first", {button_pulse, button_held}, {5'b01000, 5'b00000});
        for (int off = 1; off <= 60; off++) begin
            if (off == 47) button_in = '0;
            tick();
            exp3 = {(off == 20 || off == 28 || off == 36 || off == 44),
                    (off >= 20 && off < 52), (off < 52)};
            check($sformatf("hold3_off%0d", off),
                  {button_pulse[3], button_held[3], button_level[3]}, exp3);
        end

        // Centre button is masked from repeat.
        button_in = 5'b00001;
        wait_pulse(0, 12);
        npulse  = 0;
        anyheld = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            npulse  += int'(button_pulse[0]);
            anyheld |= button_held[0];
        end
        check("bit0_extra_pulses", 32'(npulse), 32'd0);
        check("bit0_held", 32'(anyheld), 32'd0);
        check("bit0_level", 32'(button_level[0]), 32'd1);
        button_in = '0;
        repeat (8) tick();
        check("bit0_release", 32'(button_level[0]), 32'd0);

        // Simultaneous presses on bits 1 and 4.
        button_in = 5'b10010;
        wait_pulse(1, 12);
        check("dual_pulse", {button_pulse, any_pulse}, {5'b10010, 1'b1});
        tick();
        check("dual_after", {button_pulse, any_pulse}, {5'b00000, 1'b0});
        button_in = '0;
        repeat (10) tick();
        check("dual_release", 32'(button_level), 32'd0);

        // Asynchronous reset during REPEAT on bit 3, button stays held.
        button_in = 5'b01000;
        wait_pulse(3, 12);
        repeat (25) tick();
        check("rst_pre_held", 32'(button_held[3]), 32'd1);
        #2 rst = 1'b1;
        #1 check("rst_async_clear", {button_pulse, button_level, button_held, any_pulse}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("rst_re_e%0d", e), 32'(button_pulse), (e == 6) ? 32'h08 : 32'h00);
        end
        for (int off = 1; off <= 20; off++) begin
            tick();
            check($sformatf("rst_rep_off%0d", off), {button_pulse[3], button_held[3]},
                  (off == 20) ? 2'b11 : 2'b00);
        end
        button_in = '0;
        repeat (8) tick();
        check("final_idle", {button_level, button_held}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
